// File: rtl/grid_router_pkg.sv
// Shared definitions for the grid router TX/RX paths: GCR code table, sync codeword, lane states.
// The transmit encoder and the receive decode table both derive from grid_gcr_enc.
package grid_router_pkg;

  typedef enum logic [1:0] {HUNT, SLIP, LOCKED} lane_state_t;

  localparam logic [7:0] GRID_SYNC_CW = 8'hFC;

  // Two 3-bit fields framed by bit7=0 and bit3=1, so no data codeword can equal the sync word.
  function automatic logic [7:0] grid_gcr_enc(input logic [5:0] d);
    return {1'b0, d[5:3], 1'b1, d[2:0]};
  endfunction

  function automatic logic [255:0][6:0] grid_gcr_build_dec();
    logic [255:0][6:0] t;
    t = '0;
    for (int i = 0; i < 64; i++) begin
      t[grid_gcr_enc(6'(i))] = {1'b1, 6'(i)};
    end
    return t;
  endfunction

  // Indexed by the raw 8-bit word: {valid, data[5:0]}.
  localparam logic [255:0][6:0] GRID_GCR_DEC = grid_gcr_build_dec();

endpackage

// File: rtl/grid_router_lane_align.sv
// Single-lane word aligner: hunts for the sync codeword via bitslip, tracks lock, decodes GCR.
// Word classification is combinational so the top can detect cross-lane skew in the same cycle.
module grid_router_lane_align
  import grid_router_pkg::*;
#(
  parameter int unsigned SLIP_WAIT = 4,
  parameter int unsigned SYNC_CNT  = 8,
  parameter int unsigned ERR_MAX   = 4
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_vld,
  input  logic       skew,
  output logic       bitslip,
  output logic       locked,
  output logic       code_err,
  output logic       is_idle,
  output logic       is_data,
  output logic       is_invalid,
  output logic [5:0] data
);

  localparam int SC_W = $clog2(SYNC_CNT + 1);
  localparam int EC_W = $clog2(ERR_MAX + 1);
  localparam int WC_W = $clog2(SLIP_WAIT + 1);

  lane_state_t     state_reg, state_next;
  logic [SC_W-1:0] sync_cnt_reg, sync_cnt_next;
  logic [EC_W-1:0] err_cnt_reg, err_cnt_next;
  logic [WC_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic            bitslip_next, code_err_next;
  logic [6:0]      dec;
  logic            is_sync, word_bad;

  assign dec        = GRID_GCR_DEC[din];
  assign data       = dec[5:0];
  assign is_sync    = (din == GRID_SYNC_CW);
  assign locked     = (state_reg == LOCKED);
  assign is_idle    = locked && din_vld && is_sync;
  assign is_data    = locked && din_vld && dec[6];
  assign is_invalid = locked && din_vld && !is_sync && !dec[6];
  // A skewed cycle costs the lane an error count but is not its own code error.
  assign word_bad   = is_invalid || (locked && din_vld && skew);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= HUNT;
      sync_cnt_reg <= '0;
      err_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      bitslip      <= 1'b0;
      code_err     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sync_cnt_reg <= sync_cnt_next;
      err_cnt_reg  <= err_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      bitslip      <= bitslip_next;
      code_err     <= code_err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sync_cnt_next = sync_cnt_reg;
    err_cnt_next  = err_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    bitslip_next  = 1'b0;
    code_err_next = 1'b0;
    case (state_reg)
      HUNT: begin
        if (din_vld) begin
          if (is_sync) begin
            if (sync_cnt_reg == SC_W'(SYNC_CNT - 1)) begin
              state_next    = LOCKED;
              sync_cnt_next = '0;
              err_cnt_next  = '0;
            end else begin
              sync_cnt_next = sync_cnt_reg + 1'b1;
            end
          end else begin
            sync_cnt_next = '0;
            wait_cnt_next = '0;
            bitslip_next  = 1'b1;
            state_next    = SLIP;
          end
        end
      end
      SLIP: begin
        // Counts every pclk, independent of din_vld, so the deserializer settles.
        if (wait_cnt_reg == WC_W'(SLIP_WAIT - 1)) begin
          wait_cnt_next = '0;
          state_next    = HUNT;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      LOCKED: begin
        if (din_vld) begin
          code_err_next = is_invalid;
          if (word_bad) begin
            if (err_cnt_reg == EC_W'(ERR_MAX - 1)) begin
              state_next    = HUNT;
              err_cnt_next  = '0;
              sync_cnt_next = '0;
            end else begin
              err_cnt_next = err_cnt_reg + 1'b1;
            end
          end else begin
            err_cnt_next = '0;
          end
        end
      end
      default: state_next = HUNT;
    endcase
  end

endmodule

// File: rtl/grid_router_rx_align.sv
// Three-lane receive aligner: per-lane alignment/decode plus a registered combine and skew check.
// A group is emitted only when every lane is locked and carries data in the same cycle.
module grid_router_rx_align #(
  parameter int unsigned SLIP_WAIT = 4,
  parameter int unsigned SYNC_CNT  = 8,
  parameter int unsigned ERR_MAX   = 4
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [7:0] din1,
  input  logic [7:0] din2,
  input  logic [7:0] din3,
  input  logic       din_vld,
  output logic [2:0] bitslip,
  output logic [5:0] og1,
  output logic [5:0] og2,
  output logic [5:0] og3,
  output logic       ovld,
  output logic [2:0] locked,
  output logic [2:0] code_err,
  output logic       skew_err
);

  logic [7:0] din_arr [3];
  logic [5:0] lane_data [3];
  logic [2:0] lane_idle, lane_data_ok, lane_invalid;
  logic       all_locked, skew, ovld_next;

  assign din_arr[0] = din1;
  assign din_arr[1] = din2;
  assign din_arr[2] = din3;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
      grid_router_lane_align #(
        .SLIP_WAIT(SLIP_WAIT),
        .SYNC_CNT (SYNC_CNT),
        .ERR_MAX  (ERR_MAX)
      ) u_lane (
        .pclk      (pclk),
        .rst_n     (rst_n),
        .din       (din_arr[gi]),
        .din_vld   (din_vld),
        .skew      (skew),
        .bitslip   (bitslip[gi]),
        .locked    (locked[gi]),
        .code_err  (code_err[gi]),
        .is_idle   (lane_idle[gi]),
        .is_data   (lane_data_ok[gi]),
        .is_invalid(lane_invalid[gi]),
        .data      (lane_data[gi])
      );
    end
  endgenerate

  assign all_locked = &locked;
  // Skew: some lanes idle while others carry data; invalid words never complete a group.
  assign skew       = din_vld && all_locked && (|lane_idle) && (|lane_data_ok);
  assign ovld_next  = din_vld && all_locked && (&lane_data_ok) && !(|lane_invalid);

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      og1      <= '0;
      og2      <= '0;
      og3      <= '0;
      ovld     <= 1'b0;
      skew_err <= 1'b0;
    end else begin
      ovld     <= ovld_next;
      skew_err <= skew;
      if (ovld_next) begin
        og1 <= lane_data[0];
        og2 <= lane_data[1];
        og3 <= lane_data[2];
      end
    end
  end

endmodule

// File: tb/tb_grid_router_rx_align.sv
// Directed bench for grid_router_rx_align: lock, slip alignment, data, errors, skew, async reset.
// Encoded words are hand-computed: enc(d) = {0, d[5:3], 1, d[2:0]}.
module tb_grid_router_rx_align;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic [7:0] din1, din2, din3;
  logic       din_vld;
  logic [2:0] bitslip;
  logic [5:0] og1, og2, og3;
  logic       ovld;
  logic [2:0] locked;
  logic [2:0] code_err;
  logic       skew_err;

  int n_chk  = 0;
  int n_fail = 0;

  grid_router_rx_align dut (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .din1    (din1),
    .din2    (din2),
    .din3    (din3),
    .din_vld (din_vld),
    .bitslip (bitslip),
    .og1     (og1),
    .og2     (og2),
    .og3     (og3),
    .ovld    (ovld),
    .locked  (locked),
    .code_err(code_err),
    .skew_err(skew_err)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic v);
    din1    = a;
    din2    = b;
    din3    = c;
    din_vld = v;
    @(posedge pclk);
    #1;
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
    logic [15:0] x;
    x = {w, w} << n;
    return x[15:8];
  endfunction

  initial begin
    int slips1, slips_other, last_slip, min_gap, rot1, lock_step;
    slips_other = 0;
    rst_n   = 1'b0;
    din1    = 8'h00;
    din2    = 8'h00;
    din3    = 8'h00;
    din_vld = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("reset_locked", 32'(locked), 32'h0);
    check("reset_ovld", 32'(ovld), 32'h0);
    check("reset_bitslip", 32'(bitslip), 32'h0);
    check("reset_og1", 32'(og1), 32'h0);
    @(negedge pclk);
    rst_n = 1'b1;

    // Aligned lock: eight sync words
    for (int i = 1; i <= 8; i++) begin
      step(8'hFC, 8'hFC, 8'hFC, 1'b1);
      if (bitslip != 3'b000) slips_other++;
      if (i == 7) check("lock_after_7", 32'(locked), 32'h0);
    end
    check("lock_after_8", 32'(locked), 32'h7);
    check("aligned_no_slip", 32'(slips_other), 32'h0);

    // Data path
    step(8'h2D, 8'h5A, 8'h7F, 1'b1);
    check("data1_ovld", 32'(ovld), 32'h1);
    check("data1_og1", 32'(og1), 32'h15);
    check("data1_og2", 32'(og2), 32'h2A);
    check("data1_og3", 32'(og3), 32'h3F);
    step(8'h00, 8'h00, 8'h00, 1'b0);
    check("gap_ovld", 32'(ovld), 32'h0);
    check("gap_og2_hold", 32'(og2), 32'h2A);
    check("gap_code_err", 32'(code_err), 32'h0);
    step(8'h08, 8'h49, 8'h1C, 1'b1);
    check("data2_og", {14'h0, og1, og2, og3}, {14'h0, 6'h00, 6'h21, 6'h0C});
    check("data2_ovld", 32'(ovld), 32'h1);

    // Skew: lane 0 idle, lanes 1/2 data
    step(8'hFC, 8'h2D, 8'h5A, 1'b1);
    check("skew_err", 32'(skew_err), 32'h1);
    check("skew_ovld", 32'(ovld), 32'h0);
    check("skew_code_err", 32'(code_err), 32'h0);
    check("skew_og1_hold", 32'(og1), 32'h00);
    step(8'h2D, 8'h5A, 8'h7F, 1'b1);
    check("skew_pulse_end", 32'(skew_err), 32'h0);
    check("post_skew_ovld", 32'(ovld), 32'h1);

    // Three invalid words on lane 2 then valid: lock kept
    for (int i = 0; i < 3; i++) begin
      step(8'h2D, 8'h5A, 8'h00, 1'b1);
      check("retain_code_err", 32'(code_err), 32'h4);
      check("retain_ovld", 32'(ovld), 32'h0);
    end
    step(8'h2D, 8'h5A, 8'h7F, 1'b1);
    check("retain_locked", 32'(locked), 32'h7);
    check("retain_ovld_back", 32'(ovld), 32'h1);

    // Four invalid words on lane 2: lock dropped
    for (int i = 1; i <= 4; i++) begin
      step(8'h2D, 8'h5A, 8'h00, 1'b1);
      check("drop_code_err", 32'(code_err), 32'h4);
      if (i == 3) check("drop_locked_3", 32'(locked), 32'h7);
    end
    check("drop_locked_4", 32'(locked), 32'h3);
    step(8'h2D, 8'h5A, 8'h7F, 1'b1);
    check("unlocked_ovld", 32'(ovld), 32'h0);
    check("unlocked_skew", 32'(skew_err), 32'h0);
    check("hunt_slip", 32'(bitslip), 32'h4);

    // Asynchronous reset while lane 2 has bitslip high
    rst_n = 1'b0;
    #1;
    check("rst_bitslip", 32'(bitslip), 32'h0);
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_ovld", 32'(ovld), 32'h0);
    check("rst_og1", 32'(og1), 32'h0);
    din_vld = 1'b0;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    rst_n = 1'b1;

    // Misaligned lane 1: rotated by 3, one bit undone per bitslip
    rot1      = 3;
    slips1    = 0;
    last_slip = -100;
    min_gap   = 1000;
    lock_step = 0;
    for (int s = 1; s <= 60; s++) begin
      step(8'hFC, rotl(8'hFC, rot1), 8'hFC, 1'b1);
      if (bitslip[1]) begin
        slips1++;
        if (s - last_slip < min_gap) min_gap = s - last_slip;
        last_slip = s;
        rot1 = (rot1 + 7) % 8;
      end
      if (bitslip[0] || bitslip[2]) slips_other++;
      if (s == 8) check("mis_lanes02_lock", 32'(locked), 32'h5);
      if (locked == 3'b111) begin
        lock_step = s;
        break;
      end
    end
    check("mis_locked", 32'(locked), 32'h7);
    check("mis_slip_count", 32'(slips1), 32'd3);
    check("mis_other_slips", 32'(slips_other), 32'h0);
    check("mis_gap_ok", 32'(min_gap >= 5), 32'h1);
    check("mis_lock_step", 32'(lock_step), 32'd23);

    step(8'h2D, rotl(8'h5A, rot1), 8'h7F, 1'b1);
    check("relock_ovld", 32'(ovld), 32'h1);
    check("relock_og", {14'h0, og1, og2, og3}, {14'h0, 6'h15, 6'h2A, 6'h3F});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_router_rx_align.md
Name: grid_router_rx_align

Overview:
- Receive-side counterpart of the grid router transmit path.
- Sits after three 1:8 deserializers in the parallel-clock domain and accepts one 8-bit raw word per lane per valid cycle.
- Per lane, it finds word alignment by issuing bitslip pulses until a sync codeword locks, then GCR-decodes 8b to 6b.
- Emits a 3x6-bit group (ig1..ig3 equivalent) when all lanes are locked and carry data in the same cycle.

Parameters:
- SLIP_WAIT, 4: idle cycles after a bitslip pulse before the lane's word is examined again.
- SYNC_CNT, 8: consecutive sync words needed to declare lock.
- ERR_MAX, 4: consecutive invalid codewords that drop lock.

Ports:
- pclk, in, 1: parallel clock, the only clock.
- rst_n, in, 1: asynchronous active-low reset.
- din1, in, 8: raw deserialized word, lane 0.
- din2, in, 8: raw deserialized word, lane 1.
- din3, in, 8: raw deserialized word, lane 2.
- din_vld, in, 1: din1..din3 valid this cycle; common to all lanes.
- bitslip, out, 3: one-cycle slip request per lane to its deserializer.
- og1, out, 6: decoded data, lane 0.
- og2, out, 6: decoded data, lane 1.
- og3, out, 6: decoded data, lane 2.
- ovld, out, 1: og1..og3 valid.
- locked, out, 3: per-lane lock status.
- code_err, out, 3: one-cycle pulse per lane on an invalid codeword while locked.
- skew_err, out, 1: one-cycle pulse when lanes disagree on sync versus data.

Behaviour:
- Reset values: bitslip=0, og1..og3=0, ovld=0, locked=0, code_err=0, skew_err=0. All lane FSMs go to HUNT with counters cleared.
- Package constants:
  - GRID_GCR_DEC: 256-entry table mapping an 8-bit word to {valid, 6-bit data}. It is the exact inverse of the transmit encoder table.
  - GRID_SYNC_CW = 8'hFC: a non-data codeword. Its table entry is invalid as data.
- Only cycles with din_vld=1 advance lane FSMs and counters. With din_vld=0, all state holds, ovld=0, and no pulses are asserted, except an in-progress SLIP_WAIT count, which runs every pclk.
- Per-lane FSM, one instance per lane:
  - HUNT:
    - word==SYNC: sync_cnt+1. When sync_cnt reaches SYNC_CNT-1 and another SYNC arrives, go to LOCKED with err_cnt=0.
    - Non-SYNC word: sync_cnt=0, bitslip pulses high for exactly one pclk, go to SLIP.
  - SLIP: wait SLIP_WAIT pclk cycles, ignoring input, then return to HUNT. After 8 slips the deserializer wraps naturally; the FSM keeps hunting with no limit and no error.
  - LOCKED (locked=1):
    - Valid data codeword: err_cnt=0.
    - SYNC: err_cnt=0, and the lane is flagged idle.
    - Invalid codeword: code_err pulses and err_cnt+1. When err_cnt reaches ERR_MAX, go to HUNT with locked=0 and sync_cnt=0. The lane does not slip on this transition; it slips on its next non-SYNC word in HUNT.
- Output stage, registered with 1 pclk latency from the din_vld cycle:
  - ovld=1 and og1..og3 = decoded data when all three lanes are locked and all three words are valid data in the same cycle.
  - All three SYNC: ovld=0 (idle).
  - All locked, but a mix of SYNC and data across lanes: skew_err pulses and ovld=0. Each lane treats that cycle as an invalid codeword for err_cnt, but code_err does not pulse for it.
  - Any lane with an invalid codeword: ovld=0.
  - Any lane unlocked: ovld=0 and skew_err=0.
- og1..og3 hold their last value when ovld=0.
- rst_n assertion mid-stream, including during SLIP with bitslip high, immediately forces all reset values.
- Release of rst_n is synchronized externally; the block only needs asynchronous assertion.

Decomposition:
- Shared package grid_router_pkg: GRID_GCR_DEC table, GRID_SYNC_CW, and the lane-state enum {HUNT, SLIP, LOCKED}. The transmit encoder uses the same package so the tables cannot diverge.
- One sub-module, grid_router_lane_align: a single-lane FSM with its counters, bitslip, decode, and an idle/data/invalid classification.
- The top instantiates three lane aligners and contains the combine/skew stage.

Test Plan:
- Aligned lock: all lanes drive 8'hFC for 8 valid cycles -> locked=3'b111 on the cycle after the 8th SYNC, no bitslip pulses.
- Misaligned lane: lane 1 is rotated by 3 bits in the model deserializer; the model rotates back one bit per bitslip pulse -> lane 1 gives exactly 3 bitslip pulses spaced at least SLIP_WAIT+1 cycles apart, then locked[1]=1. Lanes 0 and 2 lock unaffected.
- Data path: after lock, drive encoded {6'h15, 6'h2A, 6'h3F} -> one cycle later og1=6'h15, og2=6'h2A, og3=6'h3F, ovld=1. With din_vld=0 gaps -> ovld=0 and outputs held.
- Error drop: locked lane 2 receives 4 consecutive invalid words (not SYNC, not data) -> 4 code_err[2] pulses, then locked[2]=0 and ovld=0. Three invalid words followed by a valid one -> lock retained.
- Skew: lane 0 sends SYNC while lanes 1 and 2 send data -> skew_err=1 for one cycle, ovld=0, code_err=0.
- Reset mid-slip: assert rst_n low while bitslip=1 -> bitslip, locked, and ovld all 0 immediately. Relock from HUNT after release.
